// File: rtl/tcdm_g_arbiter.sv
// Purpose : round-robin arbiter with bounded burst ownership, sharing one wide
//           TCDM SRAM port among NB_REQ requesters.
// Latency : grant and SRAM request are combinational from req_i; loads return
//           r_valid_o one cycle after grant; stores complete at grant.
// Backpressure: a requester holds req_i and its fields until its gnt_o bit rises;
//           an owner may keep the port for up to MAX_BURST consecutive grants
//           while others wait, and indefinitely when it is alone.
// Ports   : clk/rst_n (sync active-low); req_i/add_i/wen_i/wdata_i/be_i per
//           requester in; gnt_o/r_valid_o per requester out; r_rdata_o broadcast
//           load data; data_*_SRAM drive the single wide SRAM port.
module tcdm_g_arbiter #(
  parameter int unsigned NB_REQ          = 4,
  parameter int unsigned ADDR_SRAM_WIDTH = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SIZE            = 1,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
  parameter int unsigned MAX_BURST       = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NB_REQ-1:0]                      req_i,
  input  logic [NB_REQ*ADDR_SRAM_WIDTH-1:0]      add_i,
  input  logic [NB_REQ-1:0]                      wen_i,
  input  logic [NB_REQ*SIZE*DATA_WIDTH-1:0]      wdata_i,
  input  logic [NB_REQ*SIZE*BE_WIDTH-1:0]        be_i,
  output logic [NB_REQ-1:0]                      gnt_o,
  output logic [NB_REQ-1:0]                      r_valid_o,
  output logic [SIZE*DATA_WIDTH-1:0]             r_rdata_o,
  output logic                                   data_req_SRAM,
  output logic [ADDR_SRAM_WIDTH-1:0]             data_add_SRAM,
  output logic                                   data_wen_SRAM,
  output logic [SIZE*DATA_WIDTH-1:0]             data_wdata_SRAM,
  output logic [SIZE*BE_WIDTH-1:0]               data_be_SRAM,
  input  logic [SIZE*DATA_WIDTH-1:0]             data_r_rdata_SRAM
);

  localparam int unsigned OW = $clog2(NB_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam int unsigned DW = SIZE * DATA_WIDTH;
  localparam int unsigned BW = SIZE * BE_WIDTH;

  logic [OW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [NB_REQ-1:0] rv_q, rv_d;

  logic [OW-1:0]     winner;
  logic [OW-1:0]     scan_idx;
  logic              found;
  logic              any_req;
  logic              others_req;
  logic              keep;
  logic [NB_REQ-1:0] gnt;

  // Winner selection: the current owner keeps the port while its burst budget
  // lasts (or nobody else wants it); otherwise scan starting just after the
  // owner so the owner itself is considered last.
  always_comb begin
    any_req    = |req_i;
    others_req = |(req_i & ~(NB_REQ'(1) << owner_q));
    keep       = req_i[owner_q] && (burst_cnt_q != '0) &&
                 ((burst_cnt_q < CW'(MAX_BURST)) || !others_req);
    winner     = '0;
    scan_idx   = '0;
    found      = 1'b0;
    if (keep) begin
      winner = owner_q;
    end else begin
      for (int i = 1; i <= int'(NB_REQ); i++) begin
        scan_idx = OW'((int'(owner_q) + i) % int'(NB_REQ));
        if (!found && req_i[scan_idx]) begin
          winner = scan_idx;
          found  = 1'b1;
        end
      end
    end
    // With no request, winner stays 0 so the SRAM fields mirror requester 0.
    gnt = '0;
    if (any_req) gnt[winner] = 1'b1;
  end

  // Burst bookkeeping: continuing the owner's burst saturates the counter; any
  // hand-over restarts it at 1; an idle cycle ends the burst.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!any_req) begin
      burst_cnt_d = '0;
    end else if ((winner == owner_q) && (burst_cnt_q != '0)) begin
      if (burst_cnt_q < CW'(MAX_BURST)) burst_cnt_d = burst_cnt_q + CW'(1);
    end else begin
      owner_d     = winner;
      burst_cnt_d = CW'(1);
    end
    rv_d = gnt & wen_i;
  end

  // Reset also drops any load granted in the reset cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q     <= OW'(NB_REQ - 1);
      burst_cnt_q <= '0;
      rv_q        <= '0;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      rv_q        <= rv_d;
    end
  end

  assign gnt_o           = gnt;
  assign r_valid_o       = rv_q;
  assign r_rdata_o       = data_r_rdata_SRAM;
  assign data_req_SRAM   = any_req;
  assign data_add_SRAM   = add_i[winner*ADDR_SRAM_WIDTH +: ADDR_SRAM_WIDTH];
  assign data_wen_SRAM   = wen_i[winner];
  assign data_wdata_SRAM = wdata_i[winner*DW +: DW];
  assign data_be_SRAM    = be_i[winner*BW +: BW];

endmodule

// File: tb/tb_tcdm_g_arbiter.sv
module tb_tcdm_g_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            rst_n, rst_n_b;
  logic [NR-1:0]   req, wen, req_b, wen_b;
  logic [NR*AW-1:0] add;
  logic [NR*DW-1:0] wdata;
  logic [NR*BW-1:0] be;
  logic [DW-1:0]   sram_rdata;

  logic [NR-1:0]   gnt_a, rv_a, gnt_b, rv_b;
  logic [DW-1:0]   rdata_a, rdata_b;
  logic            sreq_a, swen_a, sreq_b, swen_b;
  logic [AW-1:0]   sadd_a, sadd_b;
  logic [DW-1:0]   swdata_a, swdata_b;
  logic [BW-1:0]   sbe_a, sbe_b;

  always #5 clk = ~clk;

  tcdm_g_arbiter #(.NB_REQ(NR), .ADDR_SRAM_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(1), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_a), .r_valid_o(rv_a), .r_rdata_o(rdata_a),
    .data_req_SRAM(sreq_a), .data_add_SRAM(sadd_a), .data_wen_SRAM(swen_a),
    .data_wdata_SRAM(swdata_a), .data_be_SRAM(sbe_a), .data_r_rdata_SRAM(sram_rdata));

  tcdm_g_arbiter #(.NB_REQ(NR), .ADDR_SRAM_WIDTH(AW), .DATA_WIDTH(DW), .SIZE(1), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .req_i(req_b), .add_i(add), .wen_i(wen_b), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt_b), .r_valid_o(rv_b), .r_rdata_o(rdata_b),
    .data_req_SRAM(sreq_b), .data_add_SRAM(sadd_b), .data_wen_SRAM(swen_b),
    .data_wdata_SRAM(swdata_b), .data_be_SRAM(sbe_b), .data_r_rdata_SRAM(sram_rdata));

  typedef struct {
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] wen;
    logic [NR-1:0] exp_gnt;
    logic [NR-1:0] exp_rv;
  } vec_t;

  vec_t vecs[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic r, input logic [3:0] q, input logic [3:0] w,
                      input logic [3:0] g, input logic [3:0] v, input int n);
    vec_t t;
    t.rst_n = r; t.req = q; t.wen = w; t.exp_gnt = g; t.exp_rv = v;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  function automatic logic [AW-1:0] exp_add(input int k);
    return AW'(16'h100 + k);
  endfunction
  function automatic logic [DW-1:0] exp_wdata(input int k);
    return 32'hA5A5A5A5 ^ 32'(k ^ 2);
  endfunction
  function automatic logic [BW-1:0] exp_be(input int k);
    return BW'(k + 1);
  endfunction

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    req = '0; wen = '0; req_b = '0; wen_b = '0;
    sram_rdata = '0;
    for (int k = 0; k < NR; k++) begin
      add[k*AW +: AW]   = exp_add(k);
      wdata[k*DW +: DW] = exp_wdata(k);
      be[k*BW +: BW]    = exp_be(k);
    end

    // reset state
    push(0, 4'h0, 4'h0, 4'h0, 4'h0, 2);
    // all four loading, MAX_BURST = 4: bursts of four, owner first grant is 0
    push(1, 4'hF, 4'hF, 4'h1, 4'h0, 1);
    push(1, 4'hF, 4'hF, 4'h1, 4'h1, 3);
    push(1, 4'hF, 4'hF, 4'h2, 4'h1, 1);
    push(1, 4'hF, 4'hF, 4'h2, 4'h2, 3);
    push(1, 4'hF, 4'hF, 4'h4, 4'h2, 1);
    push(1, 4'hF, 4'hF, 4'h4, 4'h4, 3);
    push(1, 4'hF, 4'hF, 4'h8, 4'h4, 1);
    push(1, 4'hF, 4'hF, 4'h8, 4'h8, 3);
    push(1, 4'hF, 4'hF, 4'h1, 4'h8, 1);
    push(1, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    // idle cycle breaks requester 0's burst, so 1 wins, then keeps
    push(1, 4'h1, 4'hF, 4'h1, 4'h0, 1);
    push(1, 4'h1, 4'hF, 4'h1, 4'h1, 1);
    push(1, 4'h0, 4'h0, 4'h0, 4'h1, 1);
    push(1, 4'h3, 4'hF, 4'h2, 4'h0, 1);
    push(1, 4'h3, 4'hF, 4'h2, 4'h2, 1);
    push(1, 4'h0, 4'h0, 4'h0, 4'h2, 1);
    // lone store requester 2 past MAX_BURST: never loses grant, no r_valid
    push(1, 4'h4, 4'h0, 4'h4, 4'h0, 6);
    push(1, 4'h0, 4'h0, 4'h0, 4'h0, 1);
    // load granted during reset is dropped; post-reset 0 and 3 -> 0
    push(0, 4'h2, 4'hF, 4'h2, 4'h0, 1);
    push(1, 4'h9, 4'hF, 4'h1, 4'h0, 1);
    push(1, 4'h0, 4'h0, 4'h0, 4'h1, 1);

    foreach (vecs[i]) begin
      int w;
      @(negedge clk);
      rst_n = vecs[i].rst_n; req = vecs[i].req; wen = vecs[i].wen;
      #1;
      check($sformatf("v%0d gnt", i), 64'(gnt_a), 64'(vecs[i].exp_gnt));
      check($sformatf("v%0d r_valid", i), 64'(rv_a), 64'(vecs[i].exp_rv));
      check($sformatf("v%0d sram_req", i), 64'(sreq_a), 64'(vecs[i].exp_gnt != 0));
      w = -1;
      for (int k = 0; k < NR; k++) if (vecs[i].exp_gnt[k]) w = k;
      if (w >= 0) begin
        check($sformatf("v%0d sram_add", i), 64'(sadd_a), 64'(exp_add(w)));
        check($sformatf("v%0d sram_wen", i), 64'(swen_a), 64'(vecs[i].wen[w]));
        check($sformatf("v%0d sram_wdata", i), 64'(swdata_a), 64'(exp_wdata(w)));
        check($sformatf("v%0d sram_be", i), 64'(sbe_a), 64'(exp_be(w)));
      end
    end

    // single load from requester 2 at address 0x05
    @(negedge clk);
    add[2*AW +: AW] = 10'h005;
    req = 4'h4; wen = 4'h4;
    #1;
    check("single gnt", 64'(gnt_a), 64'h4);
    check("single add", 64'(sadd_a), 64'h005);
    check("single wen", 64'(swen_a), 64'h1);
    @(negedge clk);
    req = 4'h0; wen = 4'h0; sram_rdata = 32'hDEADBEEF;
    #1;
    check("single r_valid", 64'(rv_a), 64'h4);
    check("single rdata", 64'(rdata_a), 64'hDEADBEEF);
    @(negedge clk);
    sram_rdata = 32'h12345678;
    #1;
    check("single r_valid drop", 64'(rv_a), 64'h0);
    check("rdata passthrough", 64'(rdata_a), 64'h12345678);

    // MAX_BURST = 1: pure round-robin, one r_valid pulse per cycle
    @(negedge clk);
    rst_n_b = 1'b1; req_b = 4'hF; wen_b = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr%0d gnt", i), 64'(gnt_b), 64'(4'b1 << (i % 4)));
      check($sformatf("rr%0d r_valid", i), 64'(rv_b),
            (i == 0) ? 64'h0 : 64'(4'b1 << ((i - 1) % 4)));
      @(negedge clk);
    end
    req_b = 4'h0;
    #1;
    check("rr tail r_valid", 64'(rv_b), 64'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tcdm_g_arbiter.md
Name: tcdm_g_arbiter

Overview:
- Round-robin arbiter with bounded burst ownership.
- Shares one wide TCDM SRAM port (SIZE banks × DATA_WIDTH, single address) among NB_REQ accelerator requesters, e.g. HWCE load/store streams.
- Drives the single-request side of the wide bank fan-out block.
- Returns per-requester read-valid strobes aligned to the 1-cycle SRAM read latency.

Parameters:
- NB_REQ, 4, number of requesters (≥2).
- ADDR_SRAM_WIDTH, 10, bank word address width.
- DATA_WIDTH, 32, per-bank data width.
- SIZE, 1, number of banks accessed in parallel.
- BE_WIDTH, DATA_WIDTH/8, per-bank byte-enable width.
- MAX_BURST, 4, maximum consecutive grants to one requester while others wait (≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_i  in  NB_REQ  per-requester request.
- add_i  in  NB_REQ×ADDR_SRAM_WIDTH  request word address.
- wen_i  in  NB_REQ  request type: 0 = store, 1 = load.
- wdata_i  in  NB_REQ×(SIZE*DATA_WIDTH)  store data.
- be_i  in  NB_REQ×(SIZE*BE_WIDTH)  byte enables.
- gnt_o  out  NB_REQ  one-hot grant, same cycle as req.
- r_valid_o  out  NB_REQ  load response valid.
- r_rdata_o  out  SIZE*DATA_WIDTH  load data, broadcast to all requesters, qualified by r_valid_o.
- data_req_SRAM  out  1  request to wide SRAM port.
- data_add_SRAM  out  ADDR_SRAM_WIDTH  address.
- data_wen_SRAM  out  1  0 = store, 1 = load.
- data_wdata_SRAM  out  SIZE*DATA_WIDTH  write data.
- data_be_SRAM  out  SIZE*BE_WIDTH  byte enables.
- data_r_rdata_SRAM  in  SIZE*DATA_WIDTH  read data, valid the cycle after a load request.

Behaviour:
- State:
  - owner: $clog2(NB_REQ) bits.
  - burst_cnt: $clog2(MAX_BURST+1) bits.
  - rv_q: NB_REQ bits.
- Reset (rst_n low at a clk edge): owner = NB_REQ-1, burst_cnt = 0, rv_q = 0.
- Combinational outputs follow req_i during and after reset. rst_n does not gate grants.
- Protocol:
  - Requester holds req_i and all its fields stable until gnt_o[k] is 1.
  - Transaction completes in the grant cycle.
  - Requester may issue a new request the next cycle.
- Winner selection (combinational):
  - If no req_i is asserted: gnt_o = 0, data_req_SRAM = 0.
  - Keep = req_i[owner] && burst_cnt != 0 && (burst_cnt < MAX_BURST || no other req_i asserted). If keep, the winner is owner.
  - Otherwise the winner is the first asserted req_i scanning owner+1, owner+2, … modulo NB_REQ. owner itself is scanned last.
  - gnt_o[winner] = 1, exactly one bit.
- SRAM outputs:
  - data_req_SRAM = |req_i.
  - add/wen/wdata/be come from the winner's inputs.
  - When there is no request, they come from index 0, don't-care.
- State update at each edge:
  - Grant to winner == owner with burst_cnt != 0: burst_cnt = min(burst_cnt+1, MAX_BURST).
  - Grant to any other case: owner = winner, burst_cnt = 1.
  - No request: owner unchanged, burst_cnt = 0. An idle cycle ends the burst.
- Saturation: a lone requester beyond MAX_BURST keeps the grant every cycle with burst_cnt saturated.
- MAX_BURST = 1 gives pure round-robin.
- Read response:
  - rv_q = gnt_o & wen_i (per bit), registered.
  - r_valid_o = rv_q.
  - r_rdata_o = data_r_rdata_SRAM, combinational passthrough.
  - Stores never produce r_valid.
  - Back-to-back loads from different requesters give consecutive single-cycle r_valid pulses with no bubble.
- Reset mid-operation: a load granted in the reset cycle produces no r_valid. The response is dropped and the SRAM read is discarded.
- Load latency: 1 cycle from grant to r_valid. Store latency: 0 (complete at grant).
- No combinational path from data_r_rdata_SRAM to any grant or request output.

Test Plan:
- Single requester 2 load, add = 0x05, SRAM returns 0xDEADBEEF → gnt_o = 0100 same cycle, data_add_SRAM = 0x05; next cycle r_valid_o = 0100, r_rdata_o = 0xDEADBEEF.
- Requesters 0–3 loading continuously from reset, MAX_BURST = 4 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; r_valid follows 1 cycle later.
- Same stimulus with MAX_BURST = 1 → grants 0,1,2,3,0,1; one r_valid pulse per cycle, correct bit each cycle.
- Requester 0 requests 2 cycles, 1 idle cycle, then requesters 0 and 1 together → third grant goes to 1 (burst broken by idle, scan starts at owner+1 = 1).
- Requester 2 alone stores 6 cycles with be = 0x3, wdata = 0xA5A5A5A5, MAX_BURST = 4 → gnt_o[2] high all 6 cycles; SRAM sees wen = 0, be = 0x3; r_valid_o stays 0.
- Requester 1 load granted in the same cycle rst_n is low → r_valid_o = 0 next cycle; post-reset requests 0 and 3 together → grant 0.
